// File: rtl/ps2_uart_pkg.sv
// Shared types and helpers for the PS/2-to-UART transmit path.
//   tx_state_t : transmitter FSM states
//   FRAME_BITS : start + 8 data + stop bits per 8N1 frame
//   baud_div() : clock cycles per bit (integer truncation)
package ps2_uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int unsigned FRAME_BITS = 10;

   function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/ps2_uart_tx_fifo.sv
// Synchronous FIFO with combinational head read.
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write request and data (ignored when full unless popping too)
//   pop          : remove head entry (ignored when empty)
//   head_c       : current head entry, valid when not empty
//   full_c       : occupancy equals DEPTH
//   empty_c      : occupancy is zero
//   level        : registered occupancy
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_c,
   output logic                       full_c,
   output logic                       empty_c,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             do_push_c;
   logic             do_pop_c;

   assign full_c  = (level_q == LW'(DEPTH));
   assign empty_c = (level_q == '0);
   assign head_c  = mem_q[rptr_q];
   assign level   = level_q;

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   always_comb begin
      do_pop_c  = pop && !empty_c;
      do_push_c = push && (!full_c || do_pop_c);
      wptr_d    = do_push_c ? wptr_q + PW'(1) : wptr_q;
      rptr_d    = do_pop_c  ? rptr_q + PW'(1) : rptr_q;
      level_d   = level_q + LW'(do_push_c) - LW'(do_pop_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         level_q <= level_d;
      end
   end

   // Storage needs no reset; only entries below level are ever read.
   always_ff @(posedge clk) begin
      if (do_push_c) begin
         mem_q[wptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/ps2_uart_tx.sv
// Buffers decoder characters and serialises them as 8N1 UART frames.
//   clk, rst  : clock, synchronous active-high reset
//   write     : one-cycle strobe, datain valid
//   datain    : character code
//   txd       : serial line, idle high
//   busy      : a frame is on the line
//   overflow  : one-cycle pulse for a dropped character
//   level     : FIFO occupancy
module ps2_uart_tx
   import ps2_uart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          write,
   input  logic [7:0]                    datain,
   output logic                          txd,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
   localparam int unsigned BW  = $clog2(DIV);

   if (DIV < 2) begin : g_div_chk
      $error("ps2_uart_tx: CLK_HZ/BAUD must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("ps2_uart_tx: FIFO_DEPTH must be a power of two >= 2");
   end

   tx_state_t     state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;

   logic          tick_c;
   logic          pop_c;
   logic [7:0]    head_c;
   logic          full_c;
   logic          empty_c;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (write),
      .wdata   (datain),
      .pop     (pop_c),
      .head_c  (head_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .level   (level)
   );

   // Last cycle of the current bit period.
   assign tick_c = (baud_q == BW'(DIV - 1));

   // Pop when idle, or at the end of a stop bit so frames run back to back.
   assign pop_c = !empty_c && ((state_q == IDLE) || ((state_q == STOP) && tick_c));

   // Next-state, shift register and registered line outputs.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      ovf_d   = write && full_c && !pop_c;

      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (pop_c) begin
               state_d = START;
               shift_d = head_c;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (tick_c) begin
               state_d = DATA;
               baud_d  = '0;
               bit_d   = 3'd0;
               txd_d   = shift_q[0];
            end
         end
         DATA: begin
            if (tick_c) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  txd_d   = shift_q[1];
               end
            end
         end
         STOP: begin
            if (tick_c) begin
               baud_d = '0;
               if (pop_c) begin
                  state_d = START;
                  shift_d = head_c;
                  txd_d   = 1'b0;
               end else begin
                  state_d = IDLE;
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'd0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign txd      = txd_q;
   assign busy     = busy_q;
   assign overflow = ovf_q;

endmodule
